fake_n64_link_ctrl: RTL

Transaction sequencer for the fake N64 controller link. Consumes the deserialized bit stream from the receive front end, decodes the command byte, collects the address and write payload, and hands the line to the transmitter with the response length once the request is complete. Owns the line-direction signal `cur_operation` and recovers the link when a frame stalls or the command is unknown.

---
 rtl/fake_n64_pkg.sv | 19 +
 rtl/fake_n64_timeout.sv | 25 ++
 rtl/fake_n64_link_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fake_n64_pkg.sv
// Shared constants and FSM state type for the fake N64 link controller.
package fake_n64_pkg;

    localparam logic [7:0] CMD_INFO   = 8'h00;
    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_WRITE  = 8'h03;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    localparam logic [8:0] LEN_INFO   = 9'd24;
    localparam logic [8:0] LEN_STATUS = 9'd32;
    localparam logic [8:0] LEN_READ   = 9'd264;
    localparam logic [8:0] LEN_WRITE  = 9'd8;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_DRAIN, S_TURN, S_TX
    } state_t;

endpackage

// File: rtl/fake_n64_timeout.sv
// Saturating idle counter: tc is high on the LIMIT-th consecutive uncleared cycle.
module fake_n64_timeout #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tc
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    assign tc = !clear && (cnt == W'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (!tc)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/fake_n64_link_ctrl.sv
// Request sequencer for the fake N64 controller link: decodes the request and hands the line to the transmitter.
// Optional WRITE support (DATA state, wr_byte/wr_valid) is built when FAKE_N64_WRITE_EN is defined.
module fake_n64_link_ctrl
    import fake_n64_pkg::*;
#(
    parameter int TURN_CYCLES  = 8,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic        sample_clk,
    input  logic        reset,
    input  logic        rx_bit_valid,
    input  logic        rx_bit,
    input  logic        tx_done,
    output logic        cur_operation,
    output logic        tx_start,
    output logic [8:0]  tx_bits,
    output logic [7:0]  cmd,
    output logic [15:0] address,
    output logic [7:0]  wr_byte,
    output logic        wr_valid,
    output logic        busy,
    output logic        err
);

    state_t     state, state_n;
    logic [8:0] bit_cnt;
    logic [7:0] cmd_byte;
    logic [8:0] len_n;
    logic       load_len, fire_start, fire_err;
    logic       timed, to_tc, turn_tc;

    assign timed = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA) || (state == S_DRAIN);
    assign busy          = (state != S_IDLE);
    assign cur_operation = (state == S_TX);
    assign cmd_byte      = {cmd[7:1], rx_bit};

    // A received bit always clears the idle counter, so it beats a same-cycle timeout.
    fake_n64_timeout #(.LIMIT(IDLE_TIMEOUT)) u_idle (
        .clk(sample_clk), .rst(reset), .clear(rx_bit_valid || !timed), .tc(to_tc)
    );

    fake_n64_timeout #(.LIMIT(TURN_CYCLES)) u_turn (
        .clk(sample_clk), .rst(reset), .clear(state != S_TURN), .tc(turn_tc)
    );

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n    = state;
        load_len   = 1'b0;
        len_n      = tx_bits;
        fire_start = 1'b0;
        fire_err   = 1'b0;
        case (state)
            S_IDLE: if (rx_bit_valid) state_n = S_CMD;
            S_CMD: if (rx_bit_valid && bit_cnt == 9'd7) begin
                case (cmd_byte)
                    CMD_INFO, CMD_RESET: begin state_n = S_TURN; load_len = 1'b1; len_n = LEN_INFO;   end
                    CMD_STATUS:          begin state_n = S_TURN; load_len = 1'b1; len_n = LEN_STATUS; end
                    CMD_READ:            state_n = S_ADDR;
`ifdef FAKE_N64_WRITE_EN
                    CMD_WRITE:           state_n = S_ADDR;
`endif
                    default:             state_n = S_DRAIN;
                endcase
            end
            S_ADDR: if (rx_bit_valid && bit_cnt == 9'd15) begin
                state_n  = S_TURN;
                load_len = 1'b1;
                len_n    = LEN_READ;
`ifdef FAKE_N64_WRITE_EN
                if (cmd == CMD_WRITE) begin
                    state_n  = S_DATA;
                    load_len = 1'b0;
                end
`endif
            end
`ifdef FAKE_N64_WRITE_EN
            S_DATA: if (rx_bit_valid && bit_cnt == 9'd255) begin
                state_n  = S_TURN;
                load_len = 1'b1;
                len_n    = LEN_WRITE;
            end
`endif
            S_DRAIN: ;
            S_TURN: if (turn_tc) begin
                state_n    = S_TX;
                fire_start = 1'b1;
            end
            S_TX: if (tx_done) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (to_tc) begin
            state_n  = S_IDLE;
            fire_err = 1'b1;
        end
    end

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            tx_start <= 1'b0;
            tx_bits  <= '0;
            cmd      <= 8'hFE;
            address  <= '0;
            err      <= 1'b0;
            bit_cnt  <= '0;
        end else begin
            tx_start <= fire_start;
            err      <= fire_err;
            if (load_len)
                tx_bits <= len_n;
            if (rx_bit_valid) begin
                case (state)
                    S_IDLE: cmd[7] <= rx_bit;
                    S_CMD:  cmd[~bit_cnt[2:0]] <= rx_bit;
                    S_ADDR: address <= {address[14:0], rx_bit};
                    default: ;
                endcase
            end
            // IDLE->CMD has already consumed the first command bit.
            if (state_n != state)
                bit_cnt <= (state == S_IDLE) ? 9'd1 : 9'd0;
            else if (rx_bit_valid && (state == S_CMD || state == S_ADDR || state == S_DATA))
                bit_cnt <= bit_cnt + 9'd1;
        end
    end

`ifdef FAKE_N64_WRITE_EN
    logic [6:0] wr_sr;

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            wr_sr    <= '0;
            wr_byte  <= '0;
            wr_valid <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            if (state == S_DATA && rx_bit_valid) begin
                wr_sr <= {wr_sr[5:0], rx_bit};
                if (bit_cnt[2:0] == 3'd7) begin
                    wr_valid <= 1'b1;
                    wr_byte  <= {wr_sr, rx_bit};
                end
            end
        end
    end
`else
    assign wr_byte  = '0;
    assign wr_valid = 1'b0;
`endif

endmodule
